// File: rtl/carregador_programa.sv
// ============================================================================
// carregador_programa
// ----------------------------------------------------------------------------
// Boot-time program loader. Receives a byte stream over a valid/ready
// handshake, packs it into 32-bit instruction words (most-significant byte
// first), writes each word to consecutive program-memory addresses, checks a
// trailing XOR checksum and then releases the processor through run.
//
// Stream: count byte N (0 means 256), 4*N instruction bytes, checksum byte
// equal to the XOR of all instruction bytes.
//
// Ports:
//   clk          - single clock shared with processor and program memory
//   rst          - synchronous active-high reset
//   rx_data      - incoming byte
//   rx_valid     - rx_data is valid
//   rx_ready     - loader accepts a byte this cycle
//   mem_data     - instruction word for the program-memory write port
//   mem_addr     - program-memory write address
//   mem_we       - program-memory write enable, one-cycle pulse per word
//   run          - processor may execute (clean load finished)
//   busy         - load in progress
//   error        - checksum mismatch, sticky until reset
//   words_loaded - number of words written so far (0..256)
// ============================================================================
module carregador_programa (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [31:0] mem_data,
   output logic [7:0]  mem_addr,
   output logic        mem_we,
   output logic        run,
   output logic        busy,
   output logic        error,
   output logic [8:0]  words_loaded
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_WRITE = 3'd2;
   localparam logic [2:0] ST_CHECK = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;
   localparam logic [2:0] ST_ERR   = 3'd5;

   logic [2:0]  r_state;
   logic [8:0]  r_count;
   logic [8:0]  r_index;
   logic [31:0] r_word;
   logic [7:0]  r_xor;
   logic [1:0]  r_byteCnt;

   logic        w_rxReady;
   logic        w_transfer;
   logic [8:0]  w_nextIndex;

   // Ready is decoded purely from state so no input reaches an output
   // combinationally; WRITE, DONE and ERR refuse bytes and the source holds.
   assign w_rxReady   = (r_state == ST_IDLE) || (r_state == ST_LOAD) ||
                        (r_state == ST_CHECK);
   assign w_transfer  = rx_valid & w_rxReady;
   assign w_nextIndex = r_index + 9'd1;

   // Main loader sequencer. Count byte 0 encodes a full 256-word image,
   // which is why the count and index are kept 9 bits wide.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_count   <= 9'd0;
         r_index   <= 9'd0;
         r_word    <= 32'd0;
         r_xor     <= 8'd0;
         r_byteCnt <= 2'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_transfer) begin
                  r_count   <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                  r_index   <= 9'd0;
                  r_xor     <= 8'd0;
                  r_byteCnt <= 2'd0;
                  r_state   <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (w_transfer) begin
                  r_word    <= {r_word[23:0], rx_data};
                  r_xor     <= r_xor ^ rx_data;
                  r_byteCnt <= r_byteCnt + 2'd1;
                  if (r_byteCnt == 2'd3) begin
                     r_state <= ST_WRITE;
                  end
               end
            end
            ST_WRITE: begin
               r_index <= w_nextIndex;
               if (w_nextIndex == r_count) begin
                  r_state <= ST_CHECK;
               end else begin
                  r_state <= ST_LOAD;
               end
            end
            ST_CHECK: begin
               if (w_transfer) begin
                  r_state <= (rx_data == r_xor) ? ST_DONE : ST_ERR;
               end
            end
            ST_DONE: begin
               r_state <= ST_DONE;
            end
            ST_ERR: begin
               r_state <= ST_ERR;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs decoded from registered state only.
   assign rx_ready     = w_rxReady;
   assign mem_we       = (r_state == ST_WRITE);
   assign mem_addr     = r_index[7:0];
   assign mem_data     = r_word;
   assign run          = (r_state == ST_DONE);
   assign error        = (r_state == ST_ERR);
   assign busy         = (r_state == ST_LOAD) || (r_state == ST_WRITE) ||
                         (r_state == ST_CHECK);
   assign words_loaded = r_index;

endmodule

// File: tb/tb_carregador_programa.sv
// ============================================================================
// tb_carregador_programa
// ----------------------------------------------------------------------------
// Self-checking bench for the program loader. Expected memory writes are
// pushed to a scoreboard queue as each word is sent and popped by a monitor
// whenever the loader pulses mem_we.
// ============================================================================
module tb_carregador_programa;

   logic        clk;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [31:0] mem_data;
   logic [7:0]  mem_addr;
   logic        mem_we;
   logic        run;
   logic        busy;
   logic        error;
   logic [8:0]  words_loaded;

   int checks   = 0;
   int failures = 0;
   int writeCount = 0;
   logic prevWe = 1'b0;
   logic [39:0] expQ[$];

   carregador_programa dut (
      .clk          (clk),
      .rst          (rst),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .mem_data     (mem_data),
      .mem_addr     (mem_addr),
      .mem_we       (mem_we),
      .run          (run),
      .busy         (busy),
      .error        (error),
      .words_loaded (words_loaded)
   );

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: every write pulse must match the oldest expected
   // write, must be a single-cycle pulse, and words_loaded must still hold
   // the index of the word being written.
   always @(negedge clk) begin
      if (mem_we) begin
         writeCount++;
         checkOutput("we_single", {31'd0, prevWe}, 32'd0);
         checkOutput("busy_write", {31'd0, busy}, 32'd1);
         if (expQ.size() == 0) begin
            checkOutput("unexpected_write", {24'd0, mem_addr}, 32'hFFFF_FFFF);
         end else begin
            logic [39:0] e;
            e = expQ.pop_front();
            checkOutput("wr_addr", {24'd0, mem_addr}, {24'd0, e[39:32]});
            checkOutput("wr_data", mem_data, e[31:0]);
            checkOutput("wr_count", {23'd0, words_loaded}, {24'd0, e[39:32]});
         end
      end
      prevWe = mem_we;
   end

   // Offer one byte until it is accepted. Ready depends only on state, so
   // the value seen at the falling edge decides the following rising edge.
   task automatic applyStimulus(input logic [7:0] b, input bit jitter);
      int guard;
      bit taken;
      guard = 0;
      taken = 0;
      while (!taken) begin
         @(negedge clk);
         rx_data  = b;
         rx_valid = jitter ? 1'($urandom_range(0, 1)) : 1'b1;
         if (rx_valid && rx_ready) taken = 1;
         guard++;
         if (guard > 500) begin
            failures++;
            $display("[TB] FAIL byte_timeout observed=stalled expected=accepted");
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "[TB] handshake timeout");
         end
      end
   endtask

   // Send one word MSB first, expecting it at addr; the write must appear
   // in the cycle right after the fourth byte.
   task automatic sendWord(input logic [7:0] addr, input logic [31:0] w, input bit jitter);
      expQ.push_back({addr, w});
      applyStimulus(w[31:24], jitter);
      applyStimulus(w[23:16], jitter);
      applyStimulus(w[15:8], jitter);
      applyStimulus(w[7:0], jitter);
      @(negedge clk);
      if (jitter) rx_valid = 1'($urandom_range(0, 1));
      checkOutput("lat_we", {31'd0, mem_we}, 32'd1);
      checkOutput("lat_ready", {31'd0, rx_ready}, 32'd0);
   endtask

   // Reset for one edge, then confirm every output is at its reset value.
   task automatic doReset();
      @(negedge clk);
      rst      = 1'b1;
      rx_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_ready", {31'd0, rx_ready}, 32'd1);
      checkOutput("rst_we",    {31'd0, mem_we},   32'd0);
      checkOutput("rst_addr",  {24'd0, mem_addr}, 32'd0);
      checkOutput("rst_data",  mem_data,          32'd0);
      checkOutput("rst_run",   {31'd0, run},      32'd0);
      checkOutput("rst_busy",  {31'd0, busy},     32'd0);
      checkOutput("rst_error", {31'd0, error},    32'd0);
      checkOutput("rst_words", {23'd0, words_loaded}, 32'd0);
      expQ.delete();
      writeCount = 0;
   endtask

   // Check the state right after the checksum edge and that the queue drained.
   task automatic checkEnd(input string tag, input bit expRun, input int expWords, input int expWrites);
      @(negedge clk);
      rx_valid = 1'b0;
      checkOutput({tag, "_run"},   {31'd0, run},   {31'd0, expRun});
      checkOutput({tag, "_error"}, {31'd0, error}, {31'd0, ~expRun});
      checkOutput({tag, "_busy"},  {31'd0, busy},  32'd0);
      checkOutput({tag, "_words"}, {23'd0, words_loaded}, 32'(expWords));
      checkOutput({tag, "_writes"}, 32'(writeCount), 32'(expWrites));
      checkOutput({tag, "_qempty"}, 32'(expQ.size()), 32'd0);
   endtask

   initial begin
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'd0;
      repeat (2) @(negedge clk);
      doReset();

      // Two-word image, good checksum, valid held high.
      $display("[TB] two-word load, good checksum");
      applyStimulus(8'h02, 0);
      checkOutput("busy_load", 32'(busy), 32'd0);
      sendWord(8'd0, 32'h1122_3344, 0);
      sendWord(8'd1, 32'hA0B0_C0D0, 0);
      applyStimulus(8'h44, 0);
      checkEnd("good2", 1'b1, 2, 2);

      // Same image with a wrong checksum: error is sticky, bytes refused.
      doReset();
      $display("[TB] two-word load, bad checksum");
      applyStimulus(8'h02, 0);
      sendWord(8'd0, 32'h1122_3344, 0);
      sendWord(8'd1, 32'hA0B0_C0D0, 0);
      applyStimulus(8'h45, 0);
      checkEnd("bad2", 1'b0, 2, 2);
      rx_valid = 1'b1;
      rx_data  = 8'h55;
      repeat (5) @(negedge clk);
      checkOutput("err_hold", {31'd0, error}, 32'd1);
      checkOutput("err_ready", {31'd0, rx_ready}, 32'd0);
      checkOutput("err_run", {31'd0, run}, 32'd0);

      // Full 256-word image; each word repeats its index in all lanes so
      // the XOR of every word is zero and the checksum is 0x00.
      doReset();
      $display("[TB] 256-word load");
      applyStimulus(8'h00, 0);
      for (int k = 0; k < 256; k++) begin
         logic [7:0] kb;
         kb = 8'(k);
         sendWord(kb, {kb, kb, kb, kb}, 0);
      end
      applyStimulus(8'h00, 0);
      checkEnd("full", 1'b1, 256, 256);

      // Single word with random valid gaps, including bytes offered in WRITE.
      doReset();
      $display("[TB] single word with random valid");
      applyStimulus(8'h01, 1);
      sendWord(8'd0, 32'hDEAD_BEEF, 1);
      applyStimulus(8'h22, 1);
      checkEnd("rand", 1'b1, 1, 1);

      // Reset in the middle of word 1 of a three-word image.
      doReset();
      $display("[TB] reset mid-word");
      applyStimulus(8'h03, 0);
      sendWord(8'd0, 32'h0102_0304, 0);
      applyStimulus(8'hAA, 0);
      applyStimulus(8'hBB, 0);
      checkOutput("mid_qempty", 32'(expQ.size()), 32'd0);
      doReset();
      applyStimulus(8'h01, 0);
      sendWord(8'd0, 32'h0000_0001, 0);
      applyStimulus(8'h01, 0);
      checkEnd("fresh", 1'b1, 1, 1);

      // Keep offering bytes after DONE: nothing is consumed or written.
      rx_valid = 1'b1;
      rx_data  = 8'h77;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("done_ready", {31'd0, rx_ready}, 32'd0);
         checkOutput("done_run",   {31'd0, run},      32'd1);
      end
      checkOutput("done_writes", 32'(writeCount), 32'd1);
      rx_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
